// File: rtl/led_fade_if.sv
// Duty-value handshake between the fade sequencer and the PWM stage.
// The master offers duty_data with duty_valid; the slave accepts it with duty_ready.
interface led_fade_if #(
    parameter int DUTY_W = 16
);
    logic [DUTY_W-1:0] duty_data;
    logic              duty_valid;
    logic              duty_ready;

    modport master (output duty_data, output duty_valid, input duty_ready);
    modport slave  (input duty_data, input duty_valid, output duty_ready);
endinterface

// File: rtl/led_fade_sequencer.sv
// Breathing-profile duty source. The duty value steps RISE -> HOLD_HI -> FALL -> HOLD_LO
// on prescaled ticks, and each new value is offered to the PWM stage over valid/ready.
module led_fade_sequencer #(
    parameter int DUTY_W      = 16,
    parameter int STEP_CYCLES = 20000,
    parameter int STEP_SIZE   = 100,
    parameter int DUTY_MIN    = 1,
    parameter int DUTY_MAX    = 14000,
    parameter int HOLD_STEPS  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    led_fade_if.master        duty,
    output logic [2:0]        state,
    output logic              cycle_done
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam int PW        = $clog2(STEP_CYCLES);
    localparam int HW        = $clog2(HOLD_STEPS + 1);
    localparam int RESTART_I = (DUTY_MIN + STEP_SIZE > DUTY_MAX) ? DUTY_MAX : DUTY_MIN + STEP_SIZE;

    localparam logic [PW-1:0]     TERM      = PW'(STEP_CYCLES - 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [HW-1:0]     HOLD_FULL = HW'(HOLD_STEPS);
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W+1)'(STEP_SIZE);
    localparam logic [DUTY_W:0]   MIN_X     = (DUTY_W+1)'(DUTY_MIN);
    localparam logic [DUTY_W:0]   MAX_X     = (DUTY_W+1)'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] MIN_V     = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] MAX_V     = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] RESTART_V = DUTY_W'(RESTART_I);

    state_t            st;
    logic [PW-1:0]     prescaler;
    logic [HW-1:0]     hold_cnt;
    logic              stall;
    logic              tick;
    logic [DUTY_W:0]   sum;
    logic [DUTY_W:0]   dif;
    logic [DUTY_W-1:0] rise_nxt;
    logic [DUTY_W-1:0] fall_nxt;

    // A stalled offer freezes the prescaler at terminal count, so the tick waits rather than drops.
    assign stall = duty.duty_valid && !duty.duty_ready;
    assign tick  = (prescaler == TERM) && !stall;

    // One extra bit catches overflow past the top and borrow below zero before saturating.
    assign sum      = {1'b0, duty.duty_data} + STEP_X;
    assign dif      = {1'b0, duty.duty_data} - STEP_X;
    assign rise_nxt = (sum >= MAX_X) ? MAX_V : sum[DUTY_W-1:0];
    assign fall_nxt = (dif[DUTY_W] || dif <= MIN_X) ? MIN_V : dif[DUTY_W-1:0];

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st              <= IDLE;
            prescaler       <= '0;
            hold_cnt        <= '0;
            duty.duty_data  <= '0;
            duty.duty_valid <= 1'b0;
            cycle_done      <= 1'b0;
        end else begin
            cycle_done <= 1'b0;

            if (tick)
                prescaler <= '0;
            else if (prescaler != TERM)
                prescaler <= prescaler + PW'(1);

            // A load on this same edge below overrides the drop.
            if (duty.duty_valid && duty.duty_ready)
                duty.duty_valid <= 1'b0;

            if (tick) begin
                if (st != IDLE && !enable) begin
                    st              <= IDLE;
                    duty.duty_data  <= '0;
                    duty.duty_valid <= 1'b1;
                end else begin
                    case (st)
                        IDLE: if (enable) begin
                            st              <= RISE;
                            duty.duty_data  <= MIN_V;
                            duty.duty_valid <= 1'b1;
                        end
                        RISE: begin
                            duty.duty_data  <= rise_nxt;
                            duty.duty_valid <= 1'b1;
                            if (rise_nxt == MAX_V) begin
                                st       <= HOLD_HI;
                                hold_cnt <= '0;
                            end
                        end
                        HOLD_HI: begin
                            if (hold_cnt == HOLD_LAST)
                                st <= FALL;
                            else
                                hold_cnt <= hold_cnt + HW'(1);
                        end
                        FALL: begin
                            duty.duty_data  <= fall_nxt;
                            duty.duty_valid <= 1'b1;
                            if (fall_nxt == MIN_V) begin
                                st       <= HOLD_LO;
                                hold_cnt <= '0;
                            end
                        end
                        HOLD_LO: begin
                            // Restart lands on the tick after HOLD_STEPS silent ticks, so the
                            // low dwell matches the silent stretch seen at the top.
                            if (hold_cnt == HOLD_FULL) begin
                                st              <= RISE;
                                duty.duty_data  <= RESTART_V;
                                duty.duty_valid <= 1'b1;
                                cycle_done      <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + HW'(1);
                            end
                        end
                        default: st <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule
